// File: rtl/msm_batch_loader_if.sv
// rtl/msm_batch_loader_if.sv - loader stream, bank, engine-control and result signals
interface msm_batch_loader_if #(
    parameter int LENGTH       = 256,
    parameter int POINT_W      = 64,
    parameter int SCALAR_WIDTH = 16,
    parameter int CYC_W        = 32
);
    // Input pair stream
    logic                                    in_valid;
    logic                                    in_ready;
    logic [POINT_W-1:0]                      in_point;
    logic [SCALAR_WIDTH-1:0]                 in_scalar;
    logic                                    in_last;

    // Parallel banks read by the engine
    logic [LENGTH-1:0][POINT_W-1:0]          G_out;
    logic [LENGTH-1:0][SCALAR_WIDTH-1:0]     x_out;

    // Engine control and result
    logic                                    msm_reset;
    logic                                    msm_done;
    logic [POINT_W-1:0]                      msm_R;

    // Result stream and status
    logic                                    out_valid;
    logic                                    out_ready;
    logic [POINT_W-1:0]                      out_R;
    logic                                    busy;
    logic [CYC_W-1:0]                        run_cycles;

    modport master (
        input  in_valid, in_point, in_scalar, in_last, msm_done, msm_R, out_ready,
        output in_ready, G_out, x_out, msm_reset, out_valid, out_R, busy, run_cycles
    );

    modport slave (
        output in_valid, in_point, in_scalar, in_last, msm_done, msm_R, out_ready,
        input  in_ready, G_out, x_out, msm_reset, out_valid, out_R, busy, run_cycles
    );
endinterface

// File: rtl/msm_batch_loader.sv
// rtl/msm_batch_loader.sv - serial-to-bank loader and run sequencer for the naive MSM engine
module msm_batch_loader #(
    parameter int                  LENGTH       = 256,
    parameter int                  POINT_W      = 64,
    parameter int                  SCALAR_WIDTH = 16,
    parameter int                  CYC_W        = 32,
    parameter logic [POINT_W-1:0]  INF_POINT    = '0
) (
    input  logic                   clk,
    input  logic                   Reset,
    msm_batch_loader_if.master     bus
);
    localparam int IDX_W = $clog2(LENGTH) + 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(LENGTH - 1);

    typedef enum logic [2:0] {
        S_LOAD   = 3'd0,
        S_PAD    = 3'd1,
        S_START  = 3'd2,
        S_RUN    = 3'd3,
        S_RESULT = 3'd4
    } state_t;

    state_t                               r_state;
    logic [IDX_W-1:0]                     r_idx;
    logic                                 r_in_ready;
    logic                                 r_busy;
    logic                                 r_msm_reset;
    logic                                 r_first_run;
    logic                                 r_out_valid;
    logic [POINT_W-1:0]                   r_out_R;
    logic [CYC_W-1:0]                     r_run_cycles;
    logic [LENGTH-1:0][POINT_W-1:0]       r_G_bank;
    logic [LENGTH-1:0][SCALAR_WIDTH-1:0]  r_x_bank;

    logic [IDX_W-2:0]                     w_slot;
    logic                                 w_beat;

    assign w_slot = r_idx[IDX_W-2:0];
    assign w_beat = r_in_ready && bus.in_valid;

    assign bus.in_ready   = r_in_ready;
    assign bus.busy       = r_busy;
    assign bus.msm_reset  = r_msm_reset;
    assign bus.out_valid  = r_out_valid;
    assign bus.out_R      = r_out_R;
    assign bus.run_cycles = r_run_cycles;
    assign bus.G_out      = r_G_bank;
    assign bus.x_out      = r_x_bank;

    // Control FSM: slot index, engine reset sequencing, run counter and result capture
    always_ff @(posedge clk or posedge Reset) begin
        if (Reset) begin
            r_state      <= S_LOAD;
            r_idx        <= '0;
            r_in_ready   <= 1'b1;
            r_busy       <= 1'b0;
            r_msm_reset  <= 1'b1;
            r_first_run  <= 1'b0;
            r_out_valid  <= 1'b0;
            r_out_R      <= INF_POINT;
            r_run_cycles <= '0;
        end else begin
            case (r_state)
                S_LOAD: begin
                    if (bus.in_valid) begin
                        if (r_idx == LAST_IDX) begin
                            // Filling the final slot starts the run; in_last is redundant here
                            r_state    <= S_START;
                            r_in_ready <= 1'b0;
                            r_busy     <= 1'b1;
                        end else if (bus.in_last) begin
                            r_state    <= S_PAD;
                            r_idx      <= r_idx + 1'b1;
                            r_in_ready <= 1'b0;
                            r_busy     <= 1'b1;
                        end else begin
                            r_idx <= r_idx + 1'b1;
                        end
                    end
                end
                S_PAD: begin
                    if (r_idx == LAST_IDX) begin
                        r_state <= S_START;
                    end else begin
                        r_idx <= r_idx + 1'b1;
                    end
                end
                S_START: begin
                    // Engine reset is still high this cycle so it sees settled banks
                    r_run_cycles <= '0;
                    r_msm_reset  <= 1'b0;
                    r_first_run  <= 1'b1;
                    r_state      <= S_RUN;
                end
                S_RUN: begin
                    r_first_run <= 1'b0;
                    if (r_run_cycles != '1) begin
                        r_run_cycles <= r_run_cycles + 1'b1;
                    end
                    // Done may still be stale from the previous run during reset release
                    if (bus.msm_done && !r_first_run) begin
                        r_out_R     <= bus.msm_R;
                        r_out_valid <= 1'b1;
                        r_msm_reset <= 1'b1;
                        r_state     <= S_RESULT;
                    end
                end
                S_RESULT: begin
                    if (bus.out_ready) begin
                        r_out_valid <= 1'b0;
                        r_idx       <= '0;
                        r_in_ready  <= 1'b1;
                        r_busy      <= 1'b0;
                        r_state     <= S_LOAD;
                    end
                end
                default: begin
                    r_state     <= S_LOAD;
                    r_idx       <= '0;
                    r_in_ready  <= 1'b1;
                    r_busy      <= 1'b0;
                    r_msm_reset <= 1'b1;
                    r_out_valid <= 1'b0;
                end
            endcase
        end
    end

    // Bank writes: stream beats in LOAD, identity padding in PAD; no reset since every batch rewrites all slots
    always_ff @(posedge clk) begin
        if (r_state == S_LOAD && w_beat) begin
            r_G_bank[w_slot] <= bus.in_point;
            r_x_bank[w_slot] <= bus.in_scalar;
        end else if (r_state == S_PAD) begin
            r_G_bank[w_slot] <= INF_POINT;
            r_x_bank[w_slot] <= '0;
        end
    end
endmodule

// File: doc/msm_batch_loader.md
Name: msm_batch_loader

Overview:
- Upstream feeder and result collector for the naive MSM engine (`msm_naive`).
- Accepts a serial valid/ready stream of (point, scalar) pairs and assembles them into the parallel `G`/`x` register banks the engine reads.
- Sequences the engine's reset-to-start control, waits for its `Done`, and returns the captured sum on a valid/ready output.
- Short batches are padded with `inf_point` and scalar 0, so padded slots add nothing to the sum.

Parameters:
- `LENGTH`, default 256, number of (point, scalar) slots. Must equal the engine's `length` parameter.
- `CYC_W`, default 32, width of the run-cycle counter.

Ports:
- `clk`  input  1  system clock, rising edge.
- `Reset`  input  1  asynchronous, active-high reset.
- `in_valid`  input  1  input pair valid.
- `in_ready`  output  1  loader can accept a pair.
- `in_point`  input  `curve_point_t`  point for the current slot.
- `in_scalar`  input  `SCALAR_WIDTH`  scalar for the current slot.
- `in_last`  input  1  marks the final pair of a batch; sampled only on an accepted beat.
- `G_out`  output  `curve_point_t [LENGTH-1:0]`  point bank, drives engine `G`.
- `x_out`  output  `SCALAR_WIDTH [LENGTH-1:0]`  scalar bank, drives engine `x`.
- `msm_reset`  output  1  drives engine `Reset`; engine runs only while this is low.
- `msm_done`  input  1  engine `Done`.
- `msm_R`  input  `curve_point_t`  engine result `R`.
- `out_valid`  output  1  result valid.
- `out_ready`  input  1  consumer accepts the result.
- `out_R`  output  `curve_point_t`  captured MSM result.
- `busy`  output  1  high in every state except LOAD.
- `run_cycles`  output  `CYC_W`  cycle count of the last or current RUN phase.

Behaviour:
- Reset values (asynchronous, on `Reset`=1):
  - state = LOAD, `idx` = 0.
  - `msm_reset` = 1, `out_valid` = 0, `out_R` = `inf_point`, `run_cycles` = 0.
  - Banks are not reset. Every batch writes all `LENGTH` slots before the engine starts, so stale bank contents never reach the engine.
- All outputs are registered. `in_ready` = (state == LOAD).
- `idx` is `$clog2(LENGTH)+1` bits wide.
- LOAD:
  - Each accepted beat (`in_valid` & `in_ready`) writes `G_out[idx]` <= `in_point` and `x_out[idx]` <= `in_scalar`.
  - If `idx` == `LENGTH`-1, the next state is START, regardless of `in_last`.
  - Else if `in_last`, the next state is PAD with `idx` <= `idx`+1.
  - Otherwise `idx` <= `idx`+1.
  - No beat: hold.
- PAD:
  - One slot per cycle: `G_out[idx]` <= `inf_point`, `x_out[idx]` <= 0.
  - After writing slot `LENGTH`-1, go to START.
  - A batch of k pairs spends `LENGTH`-k cycles in PAD.
- START:
  - One cycle with `msm_reset` still 1, so the engine sees stable banks for at least one full cycle.
  - Clears `run_cycles`; next state is RUN.
- RUN:
  - `msm_reset` = 0; `run_cycles` increments every cycle and saturates at all-ones.
  - When `msm_done` = 1: capture `out_R` <= `msm_R`, set `out_valid` <= 1, and go to RESULT. The same edge sets `msm_reset` <= 1.
  - `msm_done` is ignored on the first RUN cycle, which covers the engine's reset release.
- RESULT:
  - `out_R` is held stable while `out_valid`=1 and `out_ready`=0.
  - On `out_ready`: `out_valid` <= 0, `idx` <= 0, next state LOAD.
  - A new batch may be accepted the cycle after the handshake.
- Banks are written only in LOAD and PAD. They are constant through START, RUN and RESULT.
- `in_last` on the beat that fills slot `LENGTH`-1 is redundant and takes no extra cycle.
- Asserting `Reset` mid-RUN aborts the batch:
  - `msm_reset` goes to 1 immediately (asynchronous).
  - No `out_valid` is produced.
  - The partial batch is discarded; the next batch restarts at slot 0.
- Concurrent `out_valid` and `in_valid`: inputs stall (`in_ready`=0) until the result is taken.

Test Plan (`LENGTH`=4):
- Full batch: 4 beats of generator G with scalars 1,2,3,4 → START one cycle later, RUN, `out_valid` with `out_R` == 10G; `msm_reset` low only during RUN.
- Short batch: 2 beats (G,5), (2G,1) with `in_last` on beat 2 → 2 PAD cycles leave slots 2,3 = `inf_point`/0; `out_R` == 7G.
- Input backpressure and gaps: random `in_valid` gaps while loading 4 beats → banks match the stream in order; no slot skipped or duplicated.
- Output backpressure: hold `out_ready`=0 for 20 cycles → `out_R` stable and `in_ready`=0 throughout; on `out_ready`=1, LOAD and `in_ready`=1 the next cycle.
- Reset mid-RUN: assert `Reset` 10 cycles into RUN → `msm_reset`=1, `out_valid`=0 and `idx`=0 immediately; the following batch (G,1)×4 gives 4G.
- Back-to-back batches: second batch offered the cycle after the result handshake → accepted at once; `run_cycles` restarts from 0 and the second result is correct.
